// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller.
// Fetch FSM states and the NOP injected on a fetch timeout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Watchdog counter for the fetch controller's WAIT/DROP states.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts waiting cycles already spent; fires on the last one
    assign expired_o = en_i && !clr_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || clr_i || expired_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage controller: one outstanding imem request, IF/ID output register.
// Optional watchdog enabled by defining FETCH_TIMEOUT_EN.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              PCSrcE,
    input  logic              StallD,
    output logic              StallF,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] InstrD,
    output logic [ADDR_W-1:0] PCD,
    output logic              InstrValidD,
    output logic              fetch_err
);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] lpc_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] pcd_q;
    logic              valid_q;
    logic              valid_d;
    logic              req;
    logic              capture;
    logic              tmo;
    logic              resp;
    logic              in_wait_drop;

    assign in_wait_drop = (state_q == WAIT) || (state_q == DROP);
    assign resp         = imem_rvalid || tmo;
    assign imem_req     = req && rst;
    assign imem_addr    = PCF;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        capture = 1'b0;
        StallF  = !PCSrcE;
        unique case (state_q)
            IDLE: begin
                req = !PCSrcE;
                if (req && imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (resp) begin
                    state_d = IDLE;
                    if (!PCSrcE) begin
                        capture = 1'b1;
                        StallF  = StallD;
                        if (StallD) state_d = HOLD;
                    end
                end else if (PCSrcE) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (PCSrcE || !StallD) begin
                    state_d = IDLE;
                    StallF  = 1'b0;
                end
            end
            DROP: begin
                if (resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output valid is a one-cycle pulse unless decode is stalled
    always_comb begin
        valid_d = valid_q;
        if (capture) begin
            valid_d = 1'b1;
        end else if (PCSrcE || !StallD) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lpc_q   <= '0;
            instr_q <= DATA_W'(NOP_INSTR);
            pcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (state_q == IDLE && req && imem_gnt) begin
                lpc_q <= PCF;
            end
            if (capture) begin
                instr_q <= imem_rvalid ? imem_rdata
                                       : DATA_W'(NOP_INSTR);
                pcd_q   <= lpc_q;
            end
        end
    end

    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign InstrValidD = valid_q;

`ifdef FETCH_TIMEOUT_EN
    logic err_q;

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i    (clk),
        .rst_ni   (rst),
        .en_i     (in_wait_drop),
        .clr_i    (imem_rvalid),
        .expired_o(tmo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (tmo) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_wd;
    assign unused_wd = in_wait_drop;
    assign tmo       = 1'b0;
    assign fetch_err = (TIMEOUT_CYCLES == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch-stage controller sequencing the instruction memory for the 5-stage RV32I pipeline. Sits between `program_counter` and a handshaked instruction-memory port (one outstanding request, variable latency). Generates StallF for the PC, delivers a registered instruction/PC pair to the IF/ID boundary, holds it under decode stall, and discards stale responses on a branch/jump redirect (PCSrcE).

## Interface
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction width
- TIMEOUT_CYCLES, 255, WAIT-state watchdog limit (used only with FETCH_TIMEOUT_EN)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- PCF  in  ADDR_W  current fetch PC from program_counter
- PCSrcE  in  1  redirect from Execute; PC loads PCTargetE this cycle
- StallD  in  1  decode stall; IF/ID output must hold
- StallF  out  1  to program_counter; 1 = hold PC
- imem_req  out  1  memory request, held until imem_gnt
- imem_addr  out  ADDR_W  request address (= PCF, stable while imem_req=1)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid (one per accepted request)
- imem_rdata  in  DATA_W  response instruction
- InstrD  out  DATA_W  registered instruction to IF/ID
- PCD  out  ADDR_W  registered PC of InstrD
- InstrValidD  out  1  InstrD/PCD valid
- fetch_err  out  1  sticky watchdog error

## Operation
- States: IDLE, WAIT, HOLD, DROP.
- IDLE: imem_req = !PCSrcE, imem_addr = PCF. gnt → WAIT. StallF=1 unless PCSrcE.
- WAIT: imem_req=0. Latch request PC internally at grant.
  - rvalid & !PCSrcE & !StallD: capture rdata/PC into InstrD/PCD, InstrValidD=1, StallF=0, → IDLE.
  - rvalid & !PCSrcE & StallD: capture, InstrValidD=1, → HOLD.
  - rvalid & PCSrcE: discard, InstrValidD=0, → IDLE.
  - !rvalid & PCSrcE: → DROP.
- HOLD: InstrD/PCD/InstrValidD frozen. StallD=0: StallF=0, InstrValidD cleared next cycle unless new capture, → IDLE. PCSrcE: InstrValidD=0, → IDLE (PCSrcE beats StallD).
- DROP: wait for rvalid, discard, → IDLE. No new request issued in DROP.
- StallF = 0 whenever PCSrcE=1 (all states), so the PC always takes PCTargetE; otherwise 1 except on delivery/release cycles.
- Outside a capture cycle with StallD=0, InstrValidD deasserts (one-cycle pulse per instruction).
- Never more than one request outstanding.

## Timing
- Reset values: state IDLE, InstrD=32'h0000_0013 (NOP), PCD=0, InstrValidD=0, fetch_err=0; imem_req forced 0 while rst=0.
- First request: first rising edge after rst deasserts, imem_addr=PCF.
- Zero-wait memory (gnt in cycle N, rvalid in N+1): InstrValidD=1 at N+2; throughput one instruction per 2 cycles.
- StallF, imem_req, imem_addr are combinational from state and inputs; InstrD/PCD/InstrValidD registered.
- rst asserted mid-transaction: immediate return to IDLE; any later rvalid for the aborted request is the memory's responsibility (memory is reset on the same rst).

## Configuration
- FETCH_TIMEOUT_EN defined: counter increments each cycle in WAIT/DROP, clears on rvalid or state exit. Reaching TIMEOUT_CYCLES: fetch_err set (sticky until reset); in WAIT deliver NOP 32'h0000_0013 with latched PC as if rvalid; in DROP → IDLE. A later stray rvalid is ignored.
- Undefined: no counter, fetch_err tied 0, WAIT/DROP wait indefinitely.

## Structure
- Package fetch_pkg: state enum (IDLE, WAIT, HOLD, DROP), NOP_INSTR = 32'h0000_0013.
- Sub-module fetch_timeout_ctr (counter + compare, width $clog2(TIMEOUT_CYCLES+1)), instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset release, PCF=0, memory rdata=mem[PC/4], 1-cycle latency → InstrValidD pulses with PCD=0,4,8 on cycles 2,4,6 after release; StallF low only on delivery cycles.
- 3-cycle latency, StallD=1 when rvalid arrives, held 3 cycles → InstrD/PCD frozen, InstrValidD=1 throughout, no imem_req until StallD drops.
- PCSrcE=1 in WAIT with PCTargetE=40, response arrives 2 cycles later → response discarded, next imem_addr=40, delivered PCD=40.
- PCSrcE and rvalid same cycle → InstrValidD=0, StallF=0, next request addr = target.
- PCSrcE=1 in HOLD with StallD=1 → InstrValidD=0 next cycle, request to target.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds → fetch_err=1 after 8 WAIT cycles, InstrD=32'h0000_0013, PCD=request PC; stays 1 until rst.
